// File: rtl/button_debounce_bank.sv
// Bank of independent push-button conditioners: synchronizer, debounce,
// press/release pulses and a per-channel auto-repeat generator.

module button_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_RATE     = 2700000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic repeat_en_i,
  output logic state_o,
  output logic down_o,
  output logic up_o,
  output logic repeat_o
);

  localparam int   DCW      = $clog2(DEBOUNCE_CYCLES);
  localparam int   RMAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int   RCW      = $clog2(RMAX);
  localparam logic RELEASED = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  logic [1:0]     sync_q;
  logic           sync_n;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           state_q, state_d;
  logic           down_q, down_d;
  logic           up_q, up_d;
  logic           mismatch, accept, press_ev, release_ev;
  rpt_state_e     rpt_q, rpt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           rep_q, rep_d;

  // Sync flops reset to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {2{RELEASED}};
    else         sync_q <= {sync_q[0], raw_i};
  end

  assign sync_n = sync_q[1] ^ RELEASED;

  always_comb begin
    mismatch   = (sync_n != state_q);
    accept     = mismatch && (dcnt_q == DCW'(DEBOUNCE_CYCLES - 1));
    press_ev   = accept && !state_q;
    release_ev = accept && state_q;
    dcnt_d     = '0;
    if (mismatch && !accept) dcnt_d = dcnt_q + DCW'(1);
    state_d    = state_q ^ accept;
    down_d     = press_ev;
    up_d       = release_ev;
  end

  // Repeat only arms on a fresh accepted press, so enabling mid-hold has no effect.
  always_comb begin
    rpt_d  = rpt_q;
    rcnt_d = rcnt_q;
    rep_d  = 1'b0;
    if (!repeat_en_i || release_ev) begin
      rpt_d  = IDLE;
      rcnt_d = '0;
    end else begin
      case (rpt_q)
        IDLE: begin
          rcnt_d = '0;
          if (press_ev) rpt_d = DELAY;
        end
        DELAY: begin
          if (rcnt_q == RCW'(REPEAT_DELAY - 1)) begin
            rpt_d  = REPEAT;
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        REPEAT: begin
          if (rcnt_q == RCW'(REPEAT_RATE - 1)) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        default: begin
          rpt_d  = IDLE;
          rcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dcnt_q  <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      rpt_q   <= IDLE;
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
      rpt_q   <= rpt_d;
      rcnt_q  <= rcnt_d;
      rep_q   <= rep_d;
    end
  end

  assign state_o  = state_q;
  assign down_o   = down_q;
  assign up_o     = up_q;
  assign repeat_o = rep_q;

endmodule

module button_debounce_bank #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_RATE     = 2700000
) (
  input  logic                clk_27,
  input  logic                reset_L,
  input  logic [CHANNELS-1:0] pb_raw,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] pb_state,
  output logic [CHANNELS-1:0] pb_down,
  output logic [CHANNELS-1:0] pb_up,
  output logic [CHANNELS-1:0] pb_repeat
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    button_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_lane (
      .clk_i      (clk_27),
      .rst_ni     (reset_L),
      .raw_i      (pb_raw[g]),
      .repeat_en_i(repeat_en),
      .state_o    (pb_state[g]),
      .down_o     (pb_down[g]),
      .up_o       (pb_up[g]),
      .repeat_o   (pb_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with a short debounce and repeat timing.

module tb_button_debounce_bank;

  logic       clk_27;
  logic       reset_L;
  logic [3:0] pb_raw;
  logic       repeat_en;
  logic [3:0] pb_state, pb_down, pb_up, pb_repeat;

  int         total;
  int         passed;
  logic [3:0] acc_rep, acc_evt;

  button_debounce_bank #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .clk_27   (clk_27),
    .reset_L  (reset_L),
    .pb_raw   (pb_raw),
    .repeat_en(repeat_en),
    .pb_state (pb_state),
    .pb_down  (pb_down),
    .pb_up    (pb_up),
    .pb_repeat(pb_repeat)
  );

  initial clk_27 = 1'b0;
  always #5 clk_27 = ~clk_27;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance n edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_27);
      #1;
      acc_rep |= pb_repeat;
      acc_evt |= pb_down | pb_up;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    acc_rep = '0; acc_evt = '0;
    reset_L = 1'b0; pb_raw = 4'hF; repeat_en = 1'b0;

    // reset state
    step(3);
    chk("rst_state", pb_state, 4'b0000);
    chk("rst_pulses", pb_down | pb_up | pb_repeat, 4'b0000);
    reset_L = 1'b1;
    acc_evt = '0;
    step(8);
    chk("idle_state", pb_state, 4'b0000);
    chk("idle_evt", acc_evt, 4'b0000);

    // ch0 press: 6-edge latency, one-cycle down pulse
    pb_raw[0] = 1'b0;
    step(5);
    chk("ch0_pre_state", pb_state, 4'b0000);
    step(1);
    chk("ch0_state", pb_state, 4'b0001);
    chk("ch0_down", pb_down, 4'b0001);
    step(1);
    chk("ch0_down_end", pb_down, 4'b0000);
    chk("ch0_state_hold", pb_state, 4'b0001);

    // ch1 bounces of 3 cycles never accepted
    acc_evt = '0;
    for (int k = 0; k < 5; k++) begin
      pb_raw[1] = 1'b0;
      step(3);
      pb_raw[1] = 1'b1;
      step(3);
    end
    step(6);
    chk("ch1_bounce_state", pb_state, 4'b0001);
    chk("ch1_bounce_evt", acc_evt, 4'b0000);

    // ch0 release
    pb_raw[0] = 1'b1;
    step(5);
    chk("ch0_rel_pre", pb_state, 4'b0001);
    step(1);
    chk("ch0_up", pb_up, 4'b0001);
    chk("ch0_rel_state", pb_state, 4'b0000);

    // ch2 auto-repeat: 10 after down, then every 3
    repeat_en = 1'b1;
    pb_raw[2] = 1'b0;
    step(6);
    chk("ch2_down", pb_down, 4'b0100);
    acc_rep = '0;
    step(9);
    chk("ch2_delay_quiet", acc_rep, 4'b0000);
    step(1);
    chk("ch2_rep1", pb_repeat, 4'b0100);
    acc_rep = '0;
    step(2);
    chk("ch2_gap", acc_rep, 4'b0000);
    step(1);
    chk("ch2_rep2", pb_repeat, 4'b0100);
    pb_raw[2] = 1'b1;
    step(3);
    chk("ch2_rep3", pb_repeat, 4'b0100);
    step(3);
    chk("ch2_up", pb_up, 4'b0100);
    chk("ch2_up_norep", pb_repeat, 4'b0000);
    acc_rep = '0;
    step(12);
    chk("ch2_after_rel", acc_rep, 4'b0000);

    // ch3 repeat_en dropped then raised while held
    pb_raw[3] = 1'b0;
    step(6);
    chk("ch3_down", pb_down, 4'b1000);
    step(10);
    chk("ch3_rep1", pb_repeat, 4'b1000);
    repeat_en = 1'b0;
    acc_rep = '0;
    step(12);
    repeat_en = 1'b1;
    step(15);
    chk("ch3_no_rep", acc_rep, 4'b0000);
    pb_raw[3] = 1'b1;
    step(6);
    chk("ch3_up", pb_up, 4'b1000);

    // reset mid-DELAY with ch0 held
    pb_raw[0] = 1'b0;
    step(6);
    chk("ch0b_down", pb_down, 4'b0001);
    step(4);
    reset_L = 1'b0;
    #1;
    chk("mid_rst_state", pb_state, 4'b0000);
    chk("mid_rst_pulses", pb_down | pb_up | pb_repeat, 4'b0000);
    step(2);
    chk("mid_rst_hold", pb_state | pb_repeat, 4'b0000);
    reset_L = 1'b1;
    acc_evt = '0;
    step(5);
    chk("post_rst_pre", pb_state, 4'b0000);
    chk("post_rst_evt", acc_evt, 4'b0000);
    step(1);
    chk("post_rst_down", pb_down, 4'b0001);
    chk("post_rst_noup", pb_up, 4'b0000);
    pb_raw[0] = 1'b1;
    acc_rep = '0;
    step(6);
    chk("post_rst_up", pb_up, 4'b0001);
    chk("post_rst_norep", acc_rep, 4'b0000);
    repeat_en = 1'b0;

    // simultaneous presses on ch0 and ch3
    pb_raw = 4'b0110;
    step(5);
    chk("sim_pre", pb_down, 4'b0000);
    step(1);
    chk("sim_down", pb_down, 4'b1001);
    chk("sim_state", pb_state, 4'b1001);
    pb_raw = 4'hF;
    step(6);
    chk("sim_up", pb_up, 4'b1001);
    step(1);
    chk("sim_final", pb_state | pb_up, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
